fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Instruction fetch front end feeding the IF/ID pipeline register of the 5-stage MIPS core.
//  Issues in-order word-address requests to a variable-latency instruction memory and buffers
//  returned instructions in a DEPTH-entry FIFO. Hands them to IF/ID with valid/ready
//  (ready = IFIDWrite). Branch redirect (PCSrcS) flushes the queue and discards stale
//  in-flight responses.
// PARAMETERS
//  DEPTH     4      FIFO entries; also max outstanding memory requests (power of 2, >=2)
//  PC_W      16     word-address PC width (PC increments by 1)
//  INST_W    32     instruction width
//  RESET_PC  0      first fetch address after reset
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  redirect       in   1       taken branch/jump: flush, restart fetch at redirect_pc
//  redirect_pc    in   PC_W    new fetch address
//  imem_req_valid out  1       request valid
//  imem_req_ready in   1       memory accepts request this cycle
//  imem_req_addr  out  PC_W    request word address
//  imem_rsp_valid in   1       response valid; responses return in request order, no backpressure
//  imem_rsp_data  in   INST_W  instruction word
//  inst_valid     out  1       head of queue valid
//  inst_ready     in   1       IF/ID consumes head (IFIDWrite)
//  inst_data      out  INST_W  head instruction
//  inst_pc        out  PC_W    address of head instruction
//  inst_pc_plus1  out  PC_W    inst_pc+1 mod 2^PC_W (PlussedPC for IF/ID)
// BEHAVIOUR
//  State:
//  - fetch_pc; FIFO {data,pc} x DEPTH with rd/wr pointers and count (0..DEPTH)
//  - outstanding (0..DEPTH): requests accepted, response not yet seen
//  - kill_cnt (0..DEPTH): in-flight responses still to be discarded
//  Reset (async, rst=1): fetch_pc=RESET_PC; count=outstanding=kill_cnt=0; all FIFO entries 0;
//   inst_valid=0, inst_data=0, inst_pc=0; imem_req_valid=0 while rst=1.
//  Request: imem_req_valid = !rst && !redirect && (count+outstanding < DEPTH); addr = fetch_pc.
//   On valid&&ready: fetch_pc <= fetch_pc+1 (wraps 2^PC_W-1 -> 0); outstanding++.
//   Credit rule guarantees no FIFO overflow; killed requests hold credit until they return.
//  Response (imem_rsp_valid): outstanding--.
//   - kill_cnt>0: drop data, kill_cnt--.
//   - else: push {imem_rsp_data, pc} at tail; pc = tag FIFO parallel to outstanding requests.
//  Pop: inst_valid && inst_ready -> rd_ptr++, count--. Push and pop in same cycle allowed;
//   count unchanged.
//  Outputs: inst_valid=(count!=0); inst_data/inst_pc from head entry (combinational read,
//   no bypass). Min latency: request accepted cycle N, response N+1, inst_valid at N+2.
//  Redirect (priority over every other event in that cycle):
//   - count<=0, pointers reset; any pop or push that cycle is ignored
//   - fetch_pc <= redirect_pc; no request issued that cycle
//   - kill_cnt <= outstanding_after_this_cycle, i.e. kill_cnt+(outstanding-kill_cnt)
//     minus any response arriving this cycle; all remaining in-flight responses dropped
//   - first request to redirect_pc next cycle if credit permits
//  Back-to-back redirects: each reloads fetch_pc; kill_cnt recomputed from outstanding.
//  Reset mid-operation: immediate clear; in-flight responses after reset are the memory's
//   responsibility (memory is reset by the same rst).
//  Counters never wrap: outstanding<=DEPTH, kill_cnt<=outstanding (assertions in bench).
// TESTING
//  1 Reset: rst=1 -> inst_valid=0, inst_pc=0, imem_req_valid=0;
//    release -> req_valid=1, addr=0x0000.
//  2 Stream: ready=1, 1-cycle latency, data=0xA5A50000|addr, inst_ready=1 -> inst_pc
//    0,1,2... one per cycle from cycle 2; inst_pc_plus1=inst_pc+1.
//  3 Backpressure: inst_ready=0 -> exactly 4 requests (0..3), then req_valid=0, count=4;
//    inst_ready=1 -> pc 0,1,2,3 in order, fetch resumes at 4.
//  4 Flush: 3-cycle latency, 3 outstanding, redirect to 0x0040 -> 3 stale responses
//    dropped; next inst_pc=0x0040, data=0xA5A50040.
//  5 Wrap: redirect_pc=0xFFFF -> inst_pc 0xFFFF (plus1=0x0000), then 0x0000.
//  6 Corner: redirect coincident with rsp_valid and inst_ready pop -> neither pushed nor
//    popped, kill_cnt correct; rst asserted mid-stream -> outputs 0 same cycle.

Source files
------------

// File: rtl/fetch_prefetch_if.sv
// Fetch front-end bundle: branch redirect, instruction-memory request/response
// channels and the instruction handoff towards the IF/ID register.
interface fetch_prefetch_if #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned INST_W = 32
);
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [PC_W-1:0]   inst_pc;
    logic [PC_W-1:0]   inst_pc_plus1;

    // Fetch unit side
    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus1
    );

    // Environment side: memory, branch unit and IF/ID
    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus1
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues in-order word fetches to a variable-latency
// memory, buffers returned words with their PCs and hands them to IF/ID.
// A redirect flushes the buffer and discards every response still in flight.
module fetch_prefetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              rst,
    fetch_prefetch_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0] data_q [DEPTH];
    logic [INST_W-1:0] data_d [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [PC_W-1:0]   pc_d   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    // PCs of requests accepted but not yet answered, oldest at tag_rd_q
    logic [PC_W-1:0]   tag_q  [DEPTH];
    logic [PC_W-1:0]   tag_d  [DEPTH];
    logic [PTR_W-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;

    logic credit_ok;
    logic req_fire;
    logic push;
    logic pop;

    // Buffered plus in-flight words may never exceed the buffer, so a response always fits
    assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < SUM_W'(DEPTH);

    assign bus.imem_req_valid = !rst && !bus.redirect && credit_ok;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = (count_q != '0);
    assign bus.inst_data      = data_q[rd_ptr_q];
    assign bus.inst_pc        = pc_q[rd_ptr_q];
    assign bus.inst_pc_plus1  = pc_q[rd_ptr_q] + 1'b1;

    // Next-state: request issue, response retire/discard, FIFO push/pop, redirect override
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        data_d        = data_q;
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        tag_d         = tag_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        outstanding_d = outstanding_q;
        kill_cnt_d    = kill_cnt_q;

        req_fire = bus.imem_req_valid && bus.imem_req_ready;
        push     = bus.imem_rsp_valid && (kill_cnt_q == '0);
        pop      = bus.inst_valid && bus.inst_ready;

        if (req_fire) begin
            tag_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d        = tag_wr_q + 1'b1;
            fetch_pc_d      = fetch_pc_q + 1'b1;
        end

        // Every response retires the oldest tag, killed or not
        if (bus.imem_rsp_valid) begin
            tag_rd_d = tag_rd_q + 1'b1;
            if (kill_cnt_q != '0) begin
                kill_cnt_d = kill_cnt_q - 1'b1;
            end
        end
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);

        if (push) begin
            data_d[wr_ptr_q] = bus.imem_rsp_data;
            pc_d[wr_ptr_q]   = tag_q[tag_rd_q];
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // No request fires during a redirect, so outstanding_d already excludes it
        if (bus.redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = bus.redirect_pc;
            kill_cnt_d = outstanding_d;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
            tag_q         <= tag_d;
        end
    end
endmodule
